// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. One 4-bit adder slice handles one nibble per
//   clock, and the carry is held in a register between slices. Valid/ready
//   handshakes are used on both the operand side and the result side.
//   WIDTH must be a multiple of 4 and at least 8.
//   Optional feature: define SIGNED_OVF_EN to add the signed-overflow output
//   'ovf'. It is captured on the final slice.

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CW+1:0]    sliceBase;
  logic [3:0]       aNib;
  logic [3:0]       bNib;
  logic [4:0]       sliceSum;
  logic             lastSlice;

  // Select the current nibble of each operand and run it through the 4-bit slice
  always_comb begin
    sliceBase = {cnt_q, 2'b00};
    aNib      = opA_q[sliceBase +: 4];
    bNib      = opB_q[sliceBase +: 4];
    sliceSum  = {1'b0, aNib} + {1'b0, bNib} + {4'b0000, carry_q};
    lastSlice = (cnt_q == LAST_NIB);
  end

  // Next-state logic: accept in IDLE, one nibble per cycle in ADD, hold result in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = a;
          opB_d   = b;
          carry_d = c;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[sliceBase +: 4] = sliceSum[3:0];
        carry_d               = sliceSum[4];
        cnt_d                 = cnt_q + 1'b1;
        if (lastSlice) begin
          cout_d  = sliceSum[4];
`ifdef SIGNED_OVF_EN
          ovf_d   = aNib[3] ^ bNib[3] ^ sliceSum[3] ^ sliceSum[4];
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs; in_ready is forced low while reset is asserted
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
`ifdef SIGNED_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Self-checking bench for nibble_serial_adder with WIDTH=16. Expected results
//   come from plain integer arithmetic on the operands. Define SIGNED_OVF_EN to
//   also check the ovf output.

module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SIGNED_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Unsigned reference: full (WIDTH+1)-bit value of a + b + c
  function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci);
    longint total;
    total = longint'(x) + longint'(y) + longint'(ci);
    return (WIDTH+1)'(total);
  endfunction

  // Signed reference: overflow when the true signed sum leaves the WIDTH-bit range
  function automatic logic refOvf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci);
    longint r;
    r = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    return (r > 32767) || (r < -32768);
  endfunction

  // Drive one operation through the handshake and return what the DUT produced
  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic ci, output logic [WIDTH-1:0] s, output logic co,
                               output logic ov, output int lat, output bit timedOut);
    int n;
    n        = 0;
    timedOut = 1'b0;
    s        = '0;
    co       = 1'b0;
    ov       = 1'b0;
    lat      = -1;
    a        = x;
    b        = y;
    c        = ci;
    in_valid = 1'b1;
    out_ready = 1'b0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      timedOut = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    c = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      timedOut = 1'b1;
      return;
    end
    s  = sum;
    co = cout;
`ifdef SIGNED_OVF_EN
    ov = ovf;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reset values and in_ready low while reset is held
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got out_valid=%b sum=%h cout=%b expected 0/0000/0",
               out_valid, sum, cout);
    end
`ifdef SIGNED_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // Corner vectors: zero, full carry ripple, signed overflow, all-ones with carry-in
  task automatic test_directed();
    logic [WIDTH-1:0] va [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic [WIDTH-1:0] vb [5] = '{16'h0000, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000};
    logic             vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] s;
    logic             co, ov;
    logic [WIDTH:0]   exp;
    int               lat;
    bit               to;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(va[i], vb[i], vc[i], s, co, ov, lat, to);
      exp = refSum(va[i], vb[i], vc[i]);
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL directed_timeout[%0d]: no handshake within 20 cycles", i);
        continue;
      end
      if (lat !== NIBBLES) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NIBBLES);
      end
      checks++;
      if ({co, s} !== exp) begin
        errors++;
        $display("[TB] FAIL directed_sum[%0d]: got cout=%b sum=%h expected cout=%b sum=%h",
                 i, co, s, exp[WIDTH], exp[WIDTH-1:0]);
      end
`ifdef SIGNED_OVF_EN
      checks++;
      if (ov !== refOvf(va[i], vb[i], vc[i])) begin
        errors++;
        $display("[TB] FAIL directed_ovf[%0d]: got %b expected %b", i, ov, refOvf(va[i], vb[i], vc[i]));
      end
`endif
    end
  endtask

  // Random operands against the arithmetic reference
  task automatic test_random();
    logic [WIDTH-1:0] x, y, s;
    logic             ci, co, ov;
    logic [WIDTH:0]   exp;
    int               lat;
    bit               to;
    for (int i = 0; i < 25; i++) begin
      x  = WIDTH'($urandom);
      y  = WIDTH'($urandom);
      ci = 1'($urandom);
      applyStimulus(x, y, ci, s, co, ov, lat, to);
      exp = refSum(x, y, ci);
      checks++;
      if (to || lat !== NIBBLES || {co, s} !== exp) begin
        errors++;
        $display("[TB] FAIL random[%0d]: a=%h b=%h c=%b got cout=%b sum=%h lat=%0d expected cout=%b sum=%h lat=%0d",
                 i, x, y, ci, co, s, lat, exp[WIDTH], exp[WIDTH-1:0], NIBBLES);
      end
`ifdef SIGNED_OVF_EN
      checks++;
      if (!to && ov !== refOvf(x, y, ci)) begin
        errors++;
        $display("[TB] FAIL random_ovf[%0d]: got %b expected %b", i, ov, refOvf(x, y, ci));
      end
`endif
    end
  endtask

  // Result held in DONE while out_ready is low; a new in_valid pulse is not taken
  task automatic test_stall();
    logic [WIDTH-1:0] x, y;
    logic [WIDTH:0]   exp;
    int               n;
    bit               bad;
    x = 16'hA5C3;
    y = 16'h6B2E;
    exp = refSum(x, y, 1'b1);
    a = x;
    b = y;
    c = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("[TB] FAIL stall_timeout: out_valid never rose");
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 16'h1111;
        b = 16'h2222;
        c = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got out_valid=%b in_ready=%b cout=%b sum=%h expected 1/0/%b/%h",
                 i, out_valid, in_ready, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    bad = 1'b0;
    repeat (NIBBLES + 3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL stall_no_accept: got a result from the pulse sent in DONE, expected none");
    end
  endtask

  // Reset during the second ADD cycle discards the operation
  task automatic test_mid_reset();
    logic [WIDTH-1:0] s;
    logic             co, ov;
    logic [WIDTH:0]   exp;
    int               lat;
    bit               to, bad;
    a = 16'hFFFF;
    b = 16'hFFFF;
    c = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_state: got out_valid=%b sum=%h cout=%b in_ready=%b expected 0/0000/0/1",
               out_valid, sum, cout, in_ready);
    end
    bad = 1'b0;
    repeat (NIBBLES + 2) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL midreset_discard: got out_valid=1 after reset, expected 0");
    end
    applyStimulus(16'h1234, 16'h4321, 1'b1, s, co, ov, lat, to);
    exp = refSum(16'h1234, 16'h4321, 1'b1);
    checks++;
    if (to || {co, s} !== exp) begin
      errors++;
      $display("[TB] FAIL midreset_next_op: got cout=%b sum=%h expected cout=%b sum=%h",
               co, s, exp[WIDTH], exp[WIDTH-1:0]);
    end
  endtask

  // in_valid and out_ready held high: accepts every NIBBLES+2 cycles, results in order
  task automatic test_back_to_back();
    logic [WIDTH:0] expQ[$];
    logic [WIDTH:0] exp;
    int             lastAccept;
    int             accepts;
    int             results;
    bit             acceptNow;
    lastAccept = -1;
    accepts    = 0;
    results    = 0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    c = 1'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acceptNow = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_spurious: got result sum=%h with nothing outstanding", sum);
        end else begin
          exp = expQ.pop_front();
          results++;
          if ({cout, sum} !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_result[%0d]: got cout=%b sum=%h expected cout=%b sum=%h",
                     results, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
      if (acceptNow) begin
        expQ.push_back(refSum(a, b, c));
        if (lastAccept >= 0) begin
          checks++;
          if (cyc - lastAccept !== NIBBLES + 2) begin
            errors++;
            $display("[TB] FAIL b2b_interval: got %0d cycles expected %0d", cyc - lastAccept, NIBBLES + 2);
          end
        end
        lastAccept = cyc;
        accepts++;
      end
      @(posedge clk); #1;
      if (acceptNow) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && expQ.size() > 0; cyc++) begin
      if (out_valid) begin
        exp = expQ.pop_front();
        results++;
        checks++;
        if ({cout, sum} !== exp) begin
          errors++;
          $display("[TB] FAIL b2b_drain[%0d]: got cout=%b sum=%h expected cout=%b sum=%h",
                   results, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (accepts < 9 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d accepts, %0d outstanding expected >=9 accepts, 0 outstanding",
               accepts, expQ.size());
    end
  endtask

  // Run every scenario in sequence, then report
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case a scenario stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
